nanov_serial_exec: RTL and testbench



---
 rtl/nanov_serial_exec_if.sv | 33 +++
 rtl/nanov_serial_exec.sv | 270 +++++++++++++++++++++++++++
 tb/tb_nanov_serial_exec.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nanov_serial_exec_if.sv
// Instruction handshake and retirement bus of the nanoV bit-serial execute unit.
// The fetch/decode side uses the master modport and the execute unit uses the slave modport.
interface nanov_serial_exec_if #(
    parameter int XLEN = 32
);
    logic            instr_valid;
    logic [31:0]     instr;
    logic            instr_ready;
    logic            done;
    logic            illegal;
    logic            store_valid;
    logic [XLEN-1:0] store_data;

    modport master (
        output instr_valid,
        output instr,
        input  instr_ready,
        input  done,
        input  illegal,
        input  store_valid,
        input  store_data
    );

    modport slave (
        input  instr_valid,
        input  instr,
        output instr_ready,
        output done,
        output illegal,
        output store_valid,
        output store_data
    );
endinterface

// File: rtl/nanov_serial_exec.sv
// nanov_serial_exec: bit-serial execute unit for RV32E OP, OP-IMM and STORE.
// One data bit is processed per clock, LSB first, over XLEN clocks. The unit
// holds its own bit-addressed register file (x0 reads as zero).
// Optional build macro NANOV_SLT_EN: when defined, SLT/SLTU are executed with
// a compare pass followed by a one-cycle FIXUP that writes the result to bit 0.
// When undefined, SLT/SLTU are rejected as illegal.
module nanov_serial_exec #(
    parameter  int XLEN      = 32,
    parameter  int REG_COUNT = 16,
    localparam int RA        = $clog2(REG_COUNT)
) (
    input  logic                  clk,
    input  logic                  rst,
    nanov_serial_exec_if.slave    bus,
    input  logic [RA-1:0]         dbg_addr,
    output logic [XLEN-1:0]       dbg_data
);

    localparam int              CW        = $clog2(XLEN);
    localparam logic [CW-1:0]   K_LAST    = CW'(XLEN - 1);
    localparam logic [6:0]      OPC_OPIMM = 7'b0010011;
    localparam logic [6:0]      OPC_OP    = 7'b0110011;
    localparam logic [6:0]      OPC_STORE = 7'b0100011;

`ifdef NANOV_SLT_EN
    typedef enum logic [1:0] {IDLE, EXEC, FIXUP} state_t;
`else
    typedef enum logic [1:0] {IDLE, EXEC} state_t;
`endif

    // A register field is out of range when it names a register that does not exist.
    function automatic logic f_reg_bad(input logic [4:0] f);
        return (32'(f) >= 32'(REG_COUNT));
    endfunction

    // Full legality check of an incoming instruction word.
    function automatic logic f_illegal(input logic [31:0] w);
        logic bad;
        bad = 1'b0;
        case (w[6:0])
            OPC_OP, OPC_OPIMM: begin
                // Shifts are not supported by this unit.
                if (w[14:12] == 3'b001 || w[14:12] == 3'b101)
                    bad = 1'b1;
`ifndef NANOV_SLT_EN
                if (w[14:12] == 3'b010 || w[14:12] == 3'b011)
                    bad = 1'b1;
`endif
                if (f_reg_bad(w[19:15]) || f_reg_bad(w[11:7]))
                    bad = 1'b1;
                // Bits 24:20 are immediate bits for OP-IMM, so only OP checks rs2.
                if (w[6:0] == OPC_OP && f_reg_bad(w[24:20]))
                    bad = 1'b1;
            end
            OPC_STORE: begin
                if (f_reg_bad(w[19:15]) || f_reg_bad(w[24:20]))
                    bad = 1'b1;
            end
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Control state
    state_t          r_state;
    logic [CW-1:0]   r_k;
    logic            r_carry;
    logic            r_ill_pend;
    logic            r_done;
    logic            r_illegal;
    logic            r_store_valid;
    logic [XLEN-1:0] r_store_data;

    // Decoded fields of the accepted instruction
    logic [RA-1:0]   r_rd;
    logic [RA-1:0]   r_rs1;
    logic [RA-1:0]   r_rs2;
    logic [2:0]      r_f3;
    logic            r_is_opimm;
    logic            r_is_store;
    logic            r_is_sub;
    logic [11:0]     r_imm;

`ifdef NANOV_SLT_EN
    logic            r_slt_res;
`endif

    // Register file, one XLEN-wide word per architectural register
    logic [XLEN-1:0] r_regs [REG_COUNT];

    // Serial datapath wires
    logic [XLEN-1:0] w_imm;
    logic            w_is_slt;
    logic            w_invert;
    logic            w_a;
    logic            w_b_src;
    logic            w_b;
    logic            w_cin;
    logic            w_sum;
    logic            w_cout;
    logic            w_res;
    logic            w_last;
    logic            w_we;
    logic [CW-1:0]   w_wr_idx;
    logic            w_wr_bit;

    // Sign-extended I-immediate, one wire per bit position
    genvar gi;
    generate
        for (gi = 0; gi < XLEN; gi++) begin : g_imm
            if (gi < 12) begin : g_low
                assign w_imm[gi] = r_imm[gi];
            end else begin : g_ext
                assign w_imm[gi] = r_imm[11];
            end
        end
    endgenerate

`ifdef NANOV_SLT_EN
    assign w_is_slt = !r_is_store && (r_f3 == 3'b010 || r_f3 == 3'b011);
`else
    assign w_is_slt = 1'b0;
`endif

    // Subtraction and compares add the inverted B operand with carry-in 1.
    assign w_invert = r_is_sub || w_is_slt;
    assign w_a      = r_regs[r_rs1][r_k];
    assign w_b_src  = r_is_opimm ? w_imm[r_k] : r_regs[r_rs2][r_k];
    assign w_b      = w_b_src ^ w_invert;
    assign w_cin    = (r_k == '0) ? w_invert : r_carry;
    assign w_sum    = w_a ^ w_b ^ w_cin;
    assign w_cout   = (w_a & w_b) | (w_cin & (w_a ^ w_b));
    assign w_last   = (r_k == K_LAST);

    // Result bit for the current position; compares write zeros above bit 0.
    always_comb begin
        w_res = 1'b0;
        case (r_f3)
            3'b000:  w_res = w_sum;
            3'b100:  w_res = w_a ^ w_b_src;
            3'b110:  w_res = w_a | w_b_src;
            3'b111:  w_res = w_a & w_b_src;
            default: w_res = 1'b0;
        endcase
    end

`ifdef NANOV_SLT_EN
    logic w_slt_res;
    // Unsigned: borrow out means a < b. Signed: differing signs decide directly.
    assign w_slt_res = (r_f3 == 3'b011) ? ~w_cout
                                        : ((w_a ^ w_b_src) ? w_a : w_sum);
`endif

    // Register-file write port selection: one bit per clock.
    always_comb begin
        w_we     = 1'b0;
        w_wr_idx = r_k;
        w_wr_bit = w_res;
        if (r_state == EXEC && !r_is_store && r_rd != '0) begin
            w_we = 1'b1;
            // Bit 0 of a compare is reserved for the FIXUP write.
            if (w_is_slt && r_k == '0)
                w_we = 1'b0;
        end
`ifdef NANOV_SLT_EN
        if (r_state == FIXUP && r_rd != '0) begin
            w_we     = 1'b1;
            w_wr_idx = '0;
            w_wr_bit = r_slt_res;
        end
`endif
    end

    // Register file: cleared on reset, single-bit writes, x0 never written.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++)
                r_regs[i] <= '0;
        end else if (w_we) begin
            r_regs[r_rd][w_wr_idx] <= w_wr_bit;
        end
    end

    // Control FSM: accept, serial execute, optional compare fixup, retire pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_k           <= '0;
            r_carry       <= 1'b0;
            r_ill_pend    <= 1'b0;
            r_done        <= 1'b0;
            r_illegal     <= 1'b0;
            r_store_valid <= 1'b0;
            r_store_data  <= '0;
            r_rd          <= '0;
            r_rs1         <= '0;
            r_rs2         <= '0;
            r_f3          <= '0;
            r_is_opimm    <= 1'b0;
            r_is_store    <= 1'b0;
            r_is_sub      <= 1'b0;
            r_imm         <= '0;
`ifdef NANOV_SLT_EN
            r_slt_res     <= 1'b0;
`endif
        end else begin
            r_done        <= 1'b0;
            r_illegal     <= 1'b0;
            r_store_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (r_ill_pend) begin
                        // Rejected instruction retires one cycle after acceptance.
                        r_ill_pend <= 1'b0;
                        r_done     <= 1'b1;
                        r_illegal  <= 1'b1;
                    end else if (bus.instr_valid) begin
                        r_k        <= '0;
                        r_rd       <= bus.instr[7 +: RA];
                        r_rs1      <= bus.instr[15 +: RA];
                        r_rs2      <= bus.instr[20 +: RA];
                        r_f3       <= bus.instr[14:12];
                        r_is_opimm <= (bus.instr[6:0] == OPC_OPIMM);
                        r_is_store <= (bus.instr[6:0] == OPC_STORE);
                        r_is_sub   <= (bus.instr[6:0] == OPC_OP) && bus.instr[30]
                                      && (bus.instr[14:12] == 3'b000);
                        r_imm      <= bus.instr[31:20];
                        if (f_illegal(bus.instr))
                            r_ill_pend <= 1'b1;
                        else
                            r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_carry <= w_cout;
                    r_k     <= r_k + 1'b1;
                    if (r_is_store)
                        r_store_data[r_k] <= w_b_src;
                    if (w_last) begin
                        r_state       <= IDLE;
                        r_done        <= 1'b1;
                        r_store_valid <= r_is_store;
`ifdef NANOV_SLT_EN
                        if (w_is_slt) begin
                            r_state   <= FIXUP;
                            r_done    <= 1'b0;
                            r_slt_res <= w_slt_res;
                        end
`endif
                    end
                end
`ifdef NANOV_SLT_EN
                FIXUP: begin
                    r_state <= IDLE;
                    r_done  <= 1'b1;
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.instr_ready = (r_state == IDLE) && !r_ill_pend;
    assign bus.done        = r_done;
    assign bus.illegal     = r_illegal;
    assign bus.store_valid = r_store_valid;
    assign bus.store_data  = r_store_data;
    assign dbg_data        = r_regs[dbg_addr];

endmodule

// File: tb/tb_nanov_serial_exec.sv
// Testbench for nanov_serial_exec: scoreboard of expected retirements,
// checked by a monitor on each done pulse, plus register checks via dbg port.
module tb_nanov_serial_exec;
    localparam int XLEN      = 32;
    localparam int REG_COUNT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  dbg_addr;
    logic [31:0] dbg_data;

    nanov_serial_exec_if #(.XLEN(XLEN)) bus ();

    nanov_serial_exec #(.XLEN(XLEN), .REG_COUNT(REG_COUNT)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          lat;
        bit          ill;
        bit          sv;
        logic [31:0] sd;
        logic [31:0] word;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t mon_e;
    int   mon_a;
    int   mon_lat;
    logic [31:0] m [16];

    // Record the cycle index of each acceptance edge.
    always @(posedge clk) begin
        if (!rst && bus.instr_valid && bus.instr_ready)
            acc_q.push_back(cyc);
        cyc <= cyc + 1;
    end

    // Retirement monitor: pops the scoreboard on each done pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.done) begin
                if (exp_q.size() == 0 || acc_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_done got done=1 want no retirement");
                end else begin
                    mon_e   = exp_q.pop_front();
                    mon_a   = acc_q.pop_front();
                    mon_lat = cyc - 1 - mon_a;
                    $display("txn instr=%h latency=%0d illegal=%0b store_valid=%0b store_data=%h",
                             mon_e.word, mon_lat, bus.illegal, bus.store_valid, bus.store_data);
                    checks++;
                    if (mon_lat !== mon_e.lat) begin
                        failures++;
                        $display("FAIL latency instr=%h got=%0d want=%0d", mon_e.word, mon_lat, mon_e.lat);
                    end
                    checks++;
                    if (bus.illegal !== mon_e.ill) begin
                        failures++;
                        $display("FAIL illegal instr=%h got=%b want=%b", mon_e.word, bus.illegal, mon_e.ill);
                    end
                    checks++;
                    if (bus.store_valid !== mon_e.sv) begin
                        failures++;
                        $display("FAIL store_valid instr=%h got=%b want=%b", mon_e.word, bus.store_valid, mon_e.sv);
                    end
                    if (mon_e.sv) begin
                        checks++;
                        if (bus.store_data !== mon_e.sd) begin
                            failures++;
                            $display("FAIL store_data instr=%h got=%h want=%h", mon_e.word, bus.store_data, mon_e.sd);
                        end
                    end
                end
            end else if (bus.illegal || bus.store_valid) begin
                checks++; failures++;
                $display("FAIL stray_pulse got illegal=%b store_valid=%b want 0 without done",
                         bus.illegal, bus.store_valid);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] sext12(input logic [11:0] imm);
        return {{20{imm[11]}}, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1,
                                          input logic [2:0] f3, input int rd);
        logic [4:0] a, b, d;
        a = rs1[4:0]; b = rs2[4:0]; d = rd[4:0];
        return {f7, b, a, f3, d, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input int rs1,
                                          input logic [2:0] f3, input int rd);
        logic [4:0] a, d;
        a = rs1[4:0]; d = rd[4:0];
        return {imm, a, f3, d, 7'b0010011};
    endfunction

    // Present one instruction for a single cycle; called just after a negedge.
    task automatic send(input logic [31:0] w, input int lat, input bit ill,
                        input bit sv, input logic [31:0] sd);
        exp_t e;
        e.lat = lat; e.ill = ill; e.sv = sv; e.sd = sd; e.word = w;
        exp_q.push_back(e);
        bus.instr       = w;
        bus.instr_valid = 1'b1;
        checks++;
        if (bus.instr_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_ready instr=%h got=%b want=1", w, bus.instr_ready);
        end
        @(posedge clk);
        @(negedge clk);
        bus.instr_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout got pending=%0d want=0", tag, exp_q.size());
            exp_q.delete();
            acc_q.delete();
        end
    endtask

    task automatic get_reg(input int a, output logic [31:0] v);
        dbg_addr = a[3:0];
        #1;
        v = dbg_data;
    endtask

    task automatic test_reset;
        logic [31:0] v;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.instr_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", bus.instr_ready); end
        checks++;
        if ({bus.done, bus.illegal, bus.store_valid} !== 3'b000) begin
            failures++;
            $display("FAIL reset_pulses got=%b want=000", {bus.done, bus.illegal, bus.store_valid});
        end
        checks++;
        if (bus.store_data !== 32'h0) begin failures++; $display("FAIL reset_store_data got=%h want=0", bus.store_data); end
        for (int r = 0; r < REG_COUNT; r++) begin
            get_reg(r, v);
            checks++;
            if (v !== 32'h0) begin failures++; $display("FAIL reset_reg x%0d got=%h want=0", r, v); end
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_addi;
        logic [31:0] v;
        send(32'h00500093, 32, 1'b0, 1'b0, 32'h0); drain("addi1");
        send(32'hFF900113, 32, 1'b0, 1'b0, 32'h0); drain("addi2");
        get_reg(1, v); checks++;
        if (v !== 32'h00000005) begin failures++; $display("FAIL addi_x1 got=%h want=00000005", v); end
        get_reg(2, v); checks++;
        if (v !== 32'hFFFFFFF9) begin failures++; $display("FAIL addi_x2 got=%h want=FFFFFFF9", v); end
    endtask

    task automatic test_add_sub;
        logic [31:0] v;
        send(32'h002081B3, 32, 1'b0, 1'b0, 32'h0); drain("add");
        send(32'h40208233, 32, 1'b0, 1'b0, 32'h0); drain("sub");
        send(32'h00500013, 32, 1'b0, 1'b0, 32'h0); drain("addi_x0");
        get_reg(3, v); checks++;
        if (v !== 32'hFFFFFFFE) begin failures++; $display("FAIL add_x3 got=%h want=FFFFFFFE", v); end
        get_reg(4, v); checks++;
        if (v !== 32'h0000000C) begin failures++; $display("FAIL sub_x4 got=%h want=0000000C", v); end
        get_reg(0, v); checks++;
        if (v !== 32'h0) begin failures++; $display("FAIL x0_zero got=%h want=0", v); end
    endtask

    task automatic test_slt;
        logic [31:0] v, w5, w6;
        int          lat;
        bit          ill;
`ifdef NANOV_SLT_EN
        lat = 33; ill = 1'b0; w5 = 32'h1; w6 = 32'h0;
`else
        lat = 1; ill = 1'b1; w5 = 32'hFFFFFFFF; w6 = 32'hFFFFFFFF;
`endif
        send(32'hFFF00293, 32, 1'b0, 1'b0, 32'h0); drain("preload_x5");
        send(32'hFFF00313, 32, 1'b0, 1'b0, 32'h0); drain("preload_x6");
        send(32'h001122B3, lat, ill, 1'b0, 32'h0); drain("slt");
        send(32'h00113333, lat, ill, 1'b0, 32'h0); drain("sltu");
        get_reg(5, v); checks++;
        if (v !== w5) begin failures++; $display("FAIL slt_x5 got=%h want=%h", v, w5); end
        get_reg(6, v); checks++;
        if (v !== w6) begin failures++; $display("FAIL sltu_x6 got=%h want=%h", v, w6); end
    endtask

    task automatic test_store;
        logic [31:0] v;
        send(32'h00302023, 32, 1'b0, 1'b1, 32'hFFFFFFFE); drain("sw");
        get_reg(3, v); checks++;
        if (v !== 32'hFFFFFFFE) begin failures++; $display("FAIL store_x3 got=%h want=FFFFFFFE", v); end
        get_reg(0, v); checks++;
        if (v !== 32'h0) begin failures++; $display("FAIL store_x0 got=%h want=0", v); end
        get_reg(4, v); checks++;
        if (v !== 32'h0000000C) begin failures++; $display("FAIL store_x4 got=%h want=0000000C", v); end
    endtask

    task automatic test_illegal;
        logic [31:0] v;
        send(32'h000008B3, 1, 1'b1, 1'b0, 32'h0); drain("ill_rd17");
        send(32'h00109093, 1, 1'b1, 1'b0, 32'h0); drain("ill_slli");
        send(enc_r(7'h00, 16, 1, 3'b000, 1), 1, 1'b1, 1'b0, 32'h0); drain("ill_rs2");
        send(32'h0000000B, 1, 1'b1, 1'b0, 32'h0); drain("ill_opcode");
        get_reg(1, v); checks++;
        if (v !== 32'h00000005) begin failures++; $display("FAIL illegal_x1 got=%h want=00000005", v); end
        checks++;
        if (bus.instr_ready !== 1'b1) begin failures++; $display("FAIL illegal_ready got=%b want=1", bus.instr_ready); end
        checks++;
        if (bus.store_data !== 32'hFFFFFFFE) begin
            failures++; $display("FAIL store_data_hold got=%h want=FFFFFFFE", bus.store_data);
        end
    endtask

    task automatic wait_done(input string tag);
        int n;
        bit seen;
        n = 0; seen = 1'b0;
        while (!seen && n < 50) begin
            @(negedge clk);
            n++;
            if (bus.done) seen = 1'b1;
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL %s_no_done got done=0 want=1", tag); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] v;
        send(32'h06400413, 32, 1'b0, 1'b0, 32'h0);
        wait_done("b2b_first");
        send(32'h00140493, 32, 1'b0, 1'b0, 32'h0);
        wait_done("b2b_second");
        send(32'h0000000B, 1, 1'b1, 1'b0, 32'h0);
        wait_done("b2b_illegal");
        send(enc_i(12'hFFF, 0, 3'b000, 10), 32, 1'b0, 1'b0, 32'h0);
        drain("b2b");
        get_reg(8, v); checks++;
        if (v !== 32'd100) begin failures++; $display("FAIL b2b_x8 got=%h want=%h", v, 32'd100); end
        get_reg(9, v); checks++;
        if (v !== 32'd101) begin failures++; $display("FAIL b2b_x9 got=%h want=%h", v, 32'd101); end
        get_reg(10, v); checks++;
        if (v !== 32'hFFFFFFFF) begin failures++; $display("FAIL b2b_x10 got=%h want=FFFFFFFF", v); end
    endtask

    task automatic test_random;
        logic [31:0] v, a, b, r;
        logic [11:0] imm;
        int          rs1, rs2, rd, op, nops, lat;
`ifdef NANOV_SLT_EN
        nops = 10;
`else
        nops = 8;
`endif
        for (int i = 1; i <= 7; i++) begin
            imm = 12'($urandom);
            m[i] = sext12(imm);
            send(enc_i(imm, 0, 3'b000, i), 32, 1'b0, 1'b0, 32'h0);
            drain("rand_load");
        end
        for (int t = 0; t < 14; t++) begin
            rs1 = $urandom_range(1, 7);
            rs2 = $urandom_range(1, 7);
            rd  = $urandom_range(1, 7);
            op  = $urandom_range(0, nops - 1);
            imm = 12'($urandom);
            a = m[rs1]; b = m[rs2]; lat = 32;
            case (op)
                0: begin r = a + b; send(enc_r(7'h00, rs2, rs1, 3'b000, rd), lat, 1'b0, 1'b0, 32'h0); end
                1: begin r = a - b; send(enc_r(7'h20, rs2, rs1, 3'b000, rd), lat, 1'b0, 1'b0, 32'h0); end
                2: begin r = a ^ b; send(enc_r(7'h00, rs2, rs1, 3'b100, rd), lat, 1'b0, 1'b0, 32'h0); end
                3: begin r = a | b; send(enc_r(7'h00, rs2, rs1, 3'b110, rd), lat, 1'b0, 1'b0, 32'h0); end
                4: begin r = a & b; send(enc_r(7'h00, rs2, rs1, 3'b111, rd), lat, 1'b0, 1'b0, 32'h0); end
                5: begin r = a ^ sext12(imm); send(enc_i(imm, rs1, 3'b100, rd), lat, 1'b0, 1'b0, 32'h0); end
                6: begin r = a | sext12(imm); send(enc_i(imm, rs1, 3'b110, rd), lat, 1'b0, 1'b0, 32'h0); end
                7: begin r = a & sext12(imm); send(enc_i(imm, rs1, 3'b111, rd), lat, 1'b0, 1'b0, 32'h0); end
                8: begin r = ($signed(a) < $signed(b)) ? 32'h1 : 32'h0;
                         send(enc_r(7'h00, rs2, rs1, 3'b010, rd), 33, 1'b0, 1'b0, 32'h0); end
                default: begin r = (a < b) ? 32'h1 : 32'h0;
                         send(enc_r(7'h00, rs2, rs1, 3'b011, rd), 33, 1'b0, 1'b0, 32'h0); end
            endcase
            m[rd] = r;
            drain("rand_op");
        end
        for (int i = 1; i <= 7; i++) begin
            get_reg(i, v); checks++;
            if (v !== m[i]) begin failures++; $display("FAIL rand_x%0d got=%h want=%h", i, v, m[i]); end
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] v;
        bit          seen;
        bus.instr       = 32'h00500093;
        bus.instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        acc_q.delete();
        checks++;
        if (bus.instr_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b want=1", bus.instr_ready); end
        checks++;
        if (bus.store_data !== 32'h0) begin failures++; $display("FAIL midrst_store_data got=%h want=0", bus.store_data); end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin failures++; $display("FAIL midrst_done got=1 want=0"); end
        get_reg(1, v); checks++;
        if (v !== 32'h0) begin failures++; $display("FAIL midrst_x1 got=%h want=0", v); end
        get_reg(8, v); checks++;
        if (v !== 32'h0) begin failures++; $display("FAIL midrst_x8 got=%h want=0", v); end
    endtask

    initial begin
        bus.instr_valid = 1'b0;
        bus.instr       = 32'h0;
        dbg_addr        = 4'h0;
        for (int i = 0; i < 16; i++) m[i] = 32'h0;
        test_reset();
        test_addi();
        test_add_sub();
        test_slt();
        test_store();
        test_illegal();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
